// File: rtl/conv_window_pkg.sv
// Shared types and constants for the sliding-window generator.
// FSM state encoding, legal kernel range, default pixel/window typedefs.
package conv_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int K_MIN     = 3;
    localparam int K_MAX     = 5;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_K     = 3;

    typedef logic [DEF_PIX_W-1:0]             pixel_t;
    typedef logic [DEF_K*DEF_K*DEF_PIX_W-1:0] window_t;

    function automatic bit k_legal(input int k);
        return (k >= K_MIN) && (k <= K_MAX) && ((k % 2) == 1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: synchronous write, asynchronous read at the same address.
module line_buffer
    import conv_window_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster pixel stream (valid mode, no padding).
// Optional stride-2 selection is built only with CONV_WINDOW_GEN_STRIDE2_EN defined.
module conv_window_gen
    import conv_window_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int K        = 3,
    parameter int MAX_COLS = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            cfg_cols,
    input  logic [15:0]            cfg_rows,
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
    input  logic                   cfg_stride2,
`endif
    input  logic [PIX_W-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [K*K*PIX_W-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   cfg_err
);

    localparam int          AW         = $clog2(MAX_COLS);
    localparam logic [15:0] KM1        = 16'(K - 1);
    localparam logic [15:0] K16        = 16'(K);
    localparam logic [31:0] MAX_COLS_U = MAX_COLS;
    localparam bit          K_OK       = k_legal(K);

    state_t      state_q, state_d;
    logic [15:0] cols_q, rows_q, col_cnt, row_cnt;
    logic [15:0] last_row_win, last_col_win;
    logic        stride_q;
    logic        cfg_ok, accept, produce, last_pix, is_last_win;
    logic        out_valid_q, out_last_q, cfg_err_q;

    logic [PIX_W-1:0] col_vec [K];
    logic [PIX_W-1:0] win [K][K];

    // An unsupported K makes every configuration illegal rather than misbehave.
    assign cfg_ok = K_OK && (cfg_cols >= K16) && (cfg_rows >= K16)
                    && ({16'd0, cfg_cols} <= MAX_COLS_U);

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;

    // K-1 is even, so the stride-2 offset parity equals the counter parity.
    assign produce  = (row_cnt >= KM1) && (col_cnt >= KM1)
                      && (!stride_q || (!row_cnt[0] && !col_cnt[0]));
    assign last_pix = (row_cnt == rows_q - 16'd1) && (col_cnt == cols_q - 16'd1);

    assign last_row_win = stride_q ? (KM1 + ((rows_q - K16) & 16'hFFFE)) : (rows_q - 16'd1);
    assign last_col_win = stride_q ? (KM1 + ((cols_q - K16) & 16'hFFFE)) : (cols_q - 16'd1);
    assign is_last_win  = (row_cnt == last_row_win) && (col_cnt == last_col_win);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && cfg_ok) state_d = ST_RUN;
            ST_RUN:   if (accept && last_pix) state_d = ST_FLUSH;
            ST_FLUSH: if (!out_valid_q || out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cols_q  <= '0;
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if ((state_q == ST_IDLE) && start && cfg_ok) begin
            cols_q  <= cfg_cols;
            rows_q  <= cfg_rows;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_cnt == cols_q - 16'd1) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 16'd1;
            end else begin
                col_cnt <= col_cnt + 16'd1;
            end
        end
    end

`ifdef CONV_WINDOW_GEN_STRIDE2_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stride_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && start && cfg_ok) begin
            stride_q <= cfg_stride2;
        end
    end
`else
    assign stride_q = 1'b0;
`endif

    // Accept is blocked while a window waits, so a window is never overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == ST_IDLE) && start && !cfg_ok;
            if (accept && produce) begin
                out_valid_q <= 1'b1;
                out_last_q  <= is_last_win;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Chain: line buffer i holds the row K-1-i rows above the incoming one.
    assign col_vec[K-1] = in_data;

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        line_buffer #(
            .DEPTH (MAX_COLS),
            .W     (PIX_W)
        ) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (col_cnt[AW-1:0]),
            .wr_data (col_vec[i+1]),
            .rd_data (col_vec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= col_vec[r];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                out_data[(r*K+c)*PIX_W +: PIX_W] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: K=3 and K=5 instances share the pixel stream.
// Expected windows are queued from a reference model and checked as they leave the DUT.
module tb_conv_window_gen;

    localparam int PW = 8;
    localparam int EW = 5*5*PW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start3, start5;
    logic [15:0] cfg_cols, cfg_rows;
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
    logic        cfg_stride2;
`endif
    logic [PW-1:0] in_data;
    logic          in_valid, out_ready;

    logic          in_ready3, out_valid3, out_last3, busy3, cfg_err3;
    logic [71:0]   out_data3;
    logic          in_ready5, out_valid5, out_last5, busy5, cfg_err5;
    logic [199:0]  out_data5;

    logic [EW-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    conv_window_gen #(.PIX_W(PW), .K(3), .MAX_COLS(256)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
        .cfg_stride2(cfg_stride2),
`endif
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_last(out_last3), .busy(busy3), .cfg_err(cfg_err3)
    );

    conv_window_gen #(.PIX_W(PW), .K(5), .MAX_COLS(256)) dut5 (
        .clk(clk), .reset(reset), .start(start5),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
        .cfg_stride2(cfg_stride2),
`endif
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready),
        .out_last(out_last5), .busy(busy5), .cfg_err(cfg_err5)
    );

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] pix(input int base, input int cols, input int r, input int c);
        return PW'(base + r*cols + c);
    endfunction

    // Reference model: every window of the frame in output order, last flag in the MSB.
    task automatic push_frame(input int k, input int cols, input int rows, input bit stride, input int base);
        logic [EW-1:0] e;
        for (int r = k - 1; r < rows; r++) begin
            for (int c = k - 1; c < cols; c++) begin
                if (stride && (((r - k + 1) % 2) != 0 || ((c - k + 1) % 2) != 0)) continue;
                e = '0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        e[(i*k+j)*PW +: PW] = pix(base, cols, r - k + 1 + i, c - k + 1 + j);
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1][EW-1] = 1'b1;
    endtask

    task automatic take(input bit k5);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_window", 1, 0);
        end else begin
            e = exp_q.pop_front();
            if (k5) check("window_k5", {out_last5, out_data5}, e);
            else    check("window_k3", {out_last3, 128'd0, out_data3}, e);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (out_valid3 && out_ready) take(1'b0);
        if (out_valid5 && out_ready) take(1'b1);
    end

    task automatic start_frame(input bit k5, input int cols, input int rows, input bit stride);
        cfg_cols = 16'(cols);
        cfg_rows = 16'(rows);
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
        cfg_stride2 = stride;
`else
        if (stride) check("stride_unsupported", 1, 0);
`endif
        if (k5) start5 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        start5 = 1'b0;
        #1;
        check("busy_after_start", k5 ? busy5 : busy3, 1);
    endtask

    task automatic stream(input bit k5, input int cols, input int rows, input int base,
                          input int stall_at, input int stop_at);
        int guard;
        logic [71:0] held;
        for (int idx = 0; idx < cols*rows; idx++) begin
            if (idx == stop_at) begin
                in_valid = 1'b0;
                return;
            end
            in_data  = pix(base, cols, idx / cols, idx % cols);
            in_valid = 1'b1;
            if (idx == stall_at) begin
                out_ready = 1'b0;
                #1;
                check("latency1_out_valid", out_valid3, 1);
                held = out_data3;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    #1;
                    check("stall_in_ready", in_ready3, 0);
                    check("stall_out_data", out_data3, held);
                end
                out_ready = 1'b1;
            end
            #1;
            guard = 0;
            while (!(k5 ? in_ready5 : in_ready3) && guard < 200) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 200) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit k5);
        int guard = 0;
        while ((k5 ? busy5 : busy3) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("idle_after_frame", k5 ? busy5 : busy3, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int rc, rr, rb;
        reset     = 1'b1;
        start3    = 1'b0;
        start5    = 1'b0;
        cfg_cols  = 16'd5;
        cfg_rows  = 16'd5;
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
        cfg_stride2 = 1'b0;
`endif
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy",      busy3,      0);
        check("reset_in_ready",  in_ready3,  0);
        check("reset_out_valid", out_valid3, 0);
        check("reset_out_last",  out_last3,  0);
        check("reset_cfg_err",   cfg_err3,   0);
        check("reset_busy_k5",   busy5,      0);

        // Illegal configurations: too narrow, too short, too wide.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            cfg_cols = (t == 0) ? 16'd2 : (t == 1) ? 16'd5 : 16'd300;
            cfg_rows = (t == 1) ? 16'd2 : 16'd5;
            start3 = 1'b1;
            @(negedge clk);
            start3 = 1'b0;
            #1;
            check("cfg_err_pulse", cfg_err3, 1);
            check("cfg_err_busy",  busy3,    0);
            @(negedge clk);
            #1;
            check("cfg_err_one_cycle", cfg_err3, 0);
        end

        // Plain 5x5 frame.
        @(negedge clk);
        push_frame(3, 5, 5, 1'b0, 0);
        start_frame(1'b0, 5, 5, 1'b0);
        stream(1'b0, 5, 5, 0, -1, -1);
        wait_idle(1'b0);

        // Same frame with a 10-cycle output stall after the first window.
        @(negedge clk);
        push_frame(3, 5, 5, 1'b0, 0);
        start_frame(1'b0, 5, 5, 1'b0);
        stream(1'b0, 5, 5, 0, 13, -1);
        wait_idle(1'b0);

        // Reset in the middle of a frame, then a fresh frame.
        @(negedge clk);
        push_frame(3, 5, 5, 1'b0, 0);
        start_frame(1'b0, 5, 5, 1'b0);
        stream(1'b0, 5, 5, 0, -1, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_busy",      busy3,      0);
        check("midreset_out_valid", out_valid3, 0);
        check("midreset_in_ready",  in_ready3,  0);
        @(negedge clk);
        push_frame(3, 5, 5, 1'b0, 0);
        start_frame(1'b0, 5, 5, 1'b0);
        stream(1'b0, 5, 5, 0, -1, -1);
        wait_idle(1'b0);

`ifdef CONV_WINDOW_GEN_STRIDE2_EN
        @(negedge clk);
        push_frame(3, 5, 5, 1'b1, 0);
        start_frame(1'b0, 5, 5, 1'b1);
        stream(1'b0, 5, 5, 0, -1, -1);
        wait_idle(1'b0);
        cfg_stride2 = 1'b0;
`endif

        // Randomly sized frame.
        rc = $urandom_range(8, 3);
        rr = $urandom_range(6, 3);
        rb = $urandom_range(200, 0);
        @(negedge clk);
        push_frame(3, rc, rr, 1'b0, rb);
        start_frame(1'b0, rc, rr, 1'b0);
        stream(1'b0, rc, rr, rb, -1, -1);
        wait_idle(1'b0);

        // K=5 on a 7x7 frame.
        @(negedge clk);
        push_frame(5, 7, 7, 1'b0, 50);
        start_frame(1'b1, 7, 7, 1'b0);
        stream(1'b1, 7, 7, 50, -1, -1);
        wait_idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The block SHALL have the parameter PIX_W, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have the parameter K, default 3, giving the odd kernel size; legal values are 3 and 5.
REQ-003 The block SHALL have the parameter MAX_COLS, default 256, giving the maximum row length in pixels.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a pulse that latches the configuration and begins a frame.
REQ-007 The block SHALL have ports cfg_cols and cfg_rows, input, 16 bits each: the frame width and height in pixels.
REQ-008 The block SHALL have port cfg_stride2, input, 1 bit: selects stride 2; it exists only under the macro in REQ-026.
REQ-009 The block SHALL have ports in_data (PIX_W bits, input), in_valid (1 bit, input) and in_ready (1 bit, output): the raster-order pixel stream.
REQ-010 The block SHALL have ports out_data (K*K*PIX_W bits, output), out_valid (1 bit, output), out_ready (1 bit, input) and out_last (1 bit, output): the window stream.
REQ-011 The block SHALL have ports busy (output, 1 bit) and cfg_err (output, 1 bit, one-cycle pulse).

Function
REQ-012 Window element (r,c) SHALL be at out_data[(r*K+c)*PIX_W +: PIX_W], where r=0 is the oldest row and c=0 the leftmost column.
REQ-013 The FSM SHALL have three states: IDLE, RUN and FLUSH.
REQ-014 In IDLE, start with a legal configuration SHALL latch the configuration, clear the counters and move to RUN.
REQ-015 The configuration is illegal when cfg_cols<K, cfg_rows<K or cfg_cols>MAX_COLS; start with an illegal configuration SHALL pulse cfg_err for one cycle and leave the FSM in IDLE.
REQ-016 start SHALL be ignored in RUN and FLUSH.
REQ-017 A pixel SHALL be accepted when in_valid&&in_ready.
REQ-018 in_ready SHALL equal (state==RUN)&&(!out_valid||out_ready).
REQ-019 On each accepted pixel, col_cnt SHALL advance; it wraps at cfg_cols-1 and then increments row_cnt.
REQ-020 A window SHALL be produced when row_cnt>=K-1 and col_cnt>=K-1 (valid mode, no padding); with stride 2, additionally (row_cnt-(K-1)) and (col_cnt-(K-1)) must both be even.
REQ-021 out_valid SHALL assert on the cycle after the accepting edge of the window's bottom-right pixel (latency 1) and hold, with out_data stable, until out_ready.
REQ-022 out_last SHALL be 1 only on the final window of the frame.
REQ-023 Acceptance of the last pixel (row cfg_rows-1, col cfg_cols-1) SHALL move the FSM to FLUSH; acceptance of the last window moves it to IDLE.
REQ-024 busy SHALL be 1 whenever the FSM is not in IDLE.

Reset
REQ-025 Reset SHALL force IDLE, zero the counters, and drive out_valid, out_last, busy, cfg_err and in_ready to 0, including mid-frame; line buffer contents are don't-care.

Configuration
REQ-026 With CONV_WINDOW_GEN_STRIDE2_EN defined, the cfg_stride2 port SHALL exist and be honoured per REQ-020; without it the port SHALL be absent and stride is fixed at 1.

Structure
REQ-027 Package conv_window_pkg SHALL hold the FSM state enum, the K range check constants and the pixel and window typedefs.
REQ-028 There SHALL be K-1 instances of the sub-module line_buffer (MAX_COLS x PIX_W, write on accept at col_cnt, asynchronous read at col_cnt); the KxK window register is held in the top level.

Verification
REQ-029 With K=3, a 5x5 frame of pixels 0..24 SHALL produce 9 windows; the first is {0,1,2,5,6,7,10,11,12}, the last is {12,13,14,17,18,19,22,23,24} with out_last=1, then IDLE.
REQ-030 With the stride-2 macro defined, K=3 and the same 5x5 frame, the output SHALL be exactly 4 windows with top-left pixels 0, 2, 10 and 12.
REQ-031 Holding out_ready=0 for 10 cycles mid-frame SHALL keep in_ready=0 and out_data stable, with no window lost or duplicated.
REQ-032 start with cfg_cols=2 SHALL pulse cfg_err once and leave busy=0.
REQ-033 Reset asserted mid-frame, then a fresh 5x5 frame, SHALL give output identical to REQ-029.
REQ-034 With K=5, a 7x7 frame SHALL produce 9 windows; the first is rows 0..4, columns 0..4.
